async_fifo_gen2: RTL

ASYNC_FIFO_GEN2 -- requirements
Module: async_fifo_gen2

---
 rtl/async_fifo_gen2_pkg.sv | 23 ++
 rtl/async_fifo_gen2_cdc_sync.sv | 25 ++
 rtl/async_fifo_gen2.sv | 132 +++++++++++++
 3 files changed

// File: rtl/async_fifo_gen2_pkg.sv
// Shared defaults and Gray-code helpers for the dual-clock FIFO.
package async_fifo_pkg;

    localparam int DSIZE_DEF       = 8;
    localparam int ASIZE_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int GRAY_W          = 32;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended Gray input converts correctly because the upper bits stay 0.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_gen2_cdc_sync.sv
// Multi-flop synchroniser for Gray-coded pointers crossing clock domains.
module cdc_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_gen2.sv
// Dual-clock FIFO with Gray pointer crossing, occupancy levels, thresholds and
// sticky overflow/underflow; read port registered or first-word-fall-through.
module async_fifo_gen2
    import async_fifo_pkg::*;
#(
    parameter int DSIZE       = DSIZE_DEF,
    parameter int ASIZE       = ASIZE_DEF,
    parameter int FWFT        = 0,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE:0]   af_thresh,
    input  logic             wovf_clr,
    output logic             wfull,
    output logic             walmost_full,
    output logic             woverflow,
    output logic [ASIZE:0]   wlevel,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    input  logic [ASIZE:0]   ae_thresh,
    input  logic             rudf_clr,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic             runderflow,
    output logic [ASIZE:0]   rlevel
);

    localparam int PW    = ASIZE + 1;
    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];

    logic [PW-1:0] wptr_bin, wptr_gray, wbin_next, wgray_next;
    logic [PW-1:0] rgray_wsync, rbin_wsync, wlevel_next;
    logic          w_accept, wfull_next;

    logic [PW-1:0] rptr_bin, rptr_gray, rbin_next, rgray_next;
    logic [PW-1:0] wgray_rsync, wbin_rsync, rlevel_next;
    logic          r_accept, rempty_next;

    // Write domain
    assign w_accept    = winc && !wfull;
    assign wbin_next   = wptr_bin + PW'(w_accept);
    assign wgray_next  = PW'(bin2gray(GRAY_W'(wbin_next)));
    assign rbin_wsync  = PW'(gray2bin(GRAY_W'(rgray_wsync)));
    assign wlevel_next = wbin_next - rbin_wsync;
    assign wfull_next  = (wgray_next == {~rgray_wsync[PW-1 -: 2], rgray_wsync[PW-3:0]});

    always_ff @(posedge wclk) begin
        if (w_accept) mem[wptr_bin[ASIZE-1:0]] <= wdata;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr_bin     <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
            wlevel       <= '0;
        end else begin
            wptr_bin     <= wbin_next;
            wptr_gray    <= wgray_next;
            wfull        <= wfull_next;
            walmost_full <= (wlevel_next >= af_thresh);
            wlevel       <= wlevel_next;
            if (winc && wfull)  woverflow <= 1'b1;
            else if (wovf_clr)  woverflow <= 1'b0;
        end
    end

    cdc_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr_gray),
        .q     (rgray_wsync)
    );

    // Read domain
    assign r_accept    = rinc && !rempty;
    assign rbin_next   = rptr_bin + PW'(r_accept);
    assign rgray_next  = PW'(bin2gray(GRAY_W'(rbin_next)));
    assign wbin_rsync  = PW'(gray2bin(GRAY_W'(wgray_rsync)));
    assign rlevel_next = wbin_rsync - rbin_next;
    assign rempty_next = (rgray_next == wgray_rsync);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rptr_bin      <= '0;
            rptr_gray     <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            runderflow    <= 1'b0;
            rlevel        <= '0;
        end else begin
            rptr_bin      <= rbin_next;
            rptr_gray     <= rgray_next;
            rempty        <= rempty_next;
            ralmost_empty <= (rlevel_next <= ae_thresh);
            rlevel        <= rlevel_next;
            if (rinc && rempty) runderflow <= 1'b1;
            else if (rudf_clr)  runderflow <= 1'b0;
        end
    end

    cdc_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr_gray),
        .q     (wgray_rsync)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is only visible once rempty has seen the synchronised write.
            assign rdata = rempty ? '0 : mem[rptr_bin[ASIZE-1:0]];
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n)       rdata_q <= '0;
                else if (r_accept) rdata_q <= mem[rptr_bin[ASIZE-1:0]];
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule
